// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 instruction, condition and status encodings
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 4'd4;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational jXX/cmovXX condition from held flags
module cond_eval
    import y86_pkg::*;
(
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic lt;

    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = !zf;
            C_GE:    cnd = !lt;
            C_G:     cnd = !lt && !zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_cond_unit.sv
// rtl/cc_cond_unit.sv - execute-stage condition-code register and branch/cmov evaluator
module cc_cond_unit
    import y86_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        e_icode,
    input  logic [3:0]        e_ifun,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_overflow,
    input  logic [STAT_W-1:0] m_stat,
    input  logic [STAT_W-1:0] w_stat,
    output logic              zf,
    output logic              sf,
    output logic              of,
    output logic              cc_upd,
    output logic              e_cnd
);

    logic set_cc;
    logic cnd;
    logic cnd_use;

    // A faulting instruction further down the pipe must not leave its
    // younger OPq's flags behind; the gate is purely per-cycle.
    assign set_cc = (e_icode == I_OPQ)
                 && (m_stat == STAT_W'(S_AOK))
                 && (w_stat == STAT_W'(S_AOK));

    always_ff @(posedge clk) begin
        if (reset) begin
            zf     <= 1'b1;
            sf     <= 1'b0;
            of     <= 1'b0;
            cc_upd <= 1'b0;
        end else if (set_cc) begin
            zf     <= (alu_result == '0);
            sf     <= alu_result[WIDTH-1];
            of     <= alu_overflow;
            cc_upd <= 1'b1;
        end else begin
            cc_upd <= 1'b0;
        end
    end

    cond_eval u_cond_eval (
        .zf   (zf),
        .sf   (sf),
        .of   (of),
        .ifun (e_ifun),
        .cnd  (cnd)
    );

    assign cnd_use = (e_icode == I_JXX) || (e_icode == I_RRMOVQ);
    assign e_cnd   = cnd_use && cnd;

endmodule

// File: tb/tb_cc_cond_unit.sv
// tb/tb_cc_cond_unit.sv - directed self-checking bench for cc_cond_unit
module tb_cc_cond_unit;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [63:0] alu_result;
    logic        alu_overflow;
    logic [2:0]  m_stat;
    logic [2:0]  w_stat;
    logic        zf, sf, of, cc_upd, e_cnd;

    int n_cmp = 0;
    int n_bad = 0;

    cc_cond_unit #(.WIDTH(64), .STAT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .e_icode      (e_icode),
        .e_ifun       (e_ifun),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .m_stat       (m_stat),
        .w_stat       (w_stat),
        .zf           (zf),
        .sf           (sf),
        .of           (of),
        .cc_upd       (cc_upd),
        .e_cnd        (e_cnd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset        = 1'b0;
        e_icode      = I_NOP;
        e_ifun       = 4'h0;
        alu_result   = 64'h0;
        alu_overflow = 1'b0;
        m_stat       = S_AOK;
        w_stat       = S_AOK;
    endtask

    task automatic opq(input logic [63:0] res, input logic ovf);
        e_icode      = I_OPQ;
        e_ifun       = 4'h0;
        alu_result   = res;
        alu_overflow = ovf;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags: got zf/sf/of/upd=%b required 1000", {zf, sf, of, cc_upd});
        end
        reset   = 1'b0;
        e_icode = I_JXX;
        e_ifun  = C_E;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_je: got e_cnd=%b required 1", e_cnd);
        end
    endtask

    task automatic test_zero_result();
        idle();
        opq(64'h0, 1'b0);
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b1001) begin
            n_bad++;
            $display("FAIL zero_flags: got zf/sf/of/upd=%b required 1001", {zf, sf, of, cc_upd});
        end
        idle();
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL zero_upd_drop: got zf/sf/of/upd=%b required 1000", {zf, sf, of, cc_upd});
        end
    endtask

    task automatic test_negative();
        idle();
        opq(64'hFFFF_FFFF_FFFF_FFF3, 1'b0);
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b0101) begin
            n_bad++;
            $display("FAIL neg_flags: got zf/sf/of/upd=%b required 0101", {zf, sf, of, cc_upd});
        end
        e_icode = I_JXX;
        e_ifun  = C_L;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL neg_jl: got e_cnd=%b required 1", e_cnd);
        end
        e_ifun = C_G;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL neg_jg: got e_cnd=%b required 0", e_cnd);
        end
        e_ifun = C_LE;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL neg_jle: got e_cnd=%b required 1", e_cnd);
        end
        e_ifun = C_E;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL neg_je: got e_cnd=%b required 0", e_cnd);
        end
    endtask

    task automatic test_overflow();
        idle();
        opq(64'h8000_0000_0000_0000, 1'b1);
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b0111) begin
            n_bad++;
            $display("FAIL ovf_flags: got zf/sf/of/upd=%b required 0111", {zf, sf, of, cc_upd});
        end
        e_icode = I_JXX;
        e_ifun  = C_L;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_jl: got e_cnd=%b required 0", e_cnd);
        end
        e_ifun = C_GE;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_jge: got e_cnd=%b required 1", e_cnd);
        end
        e_ifun = C_G;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_jg: got e_cnd=%b required 1", e_cnd);
        end
        e_icode = I_RRMOVQ;
        e_ifun  = C_NE;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_cmovne: got e_cnd=%b required 1", e_cnd);
        end
        e_ifun = 4'h7;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_cmov_ifun7: got e_cnd=%b required 0", e_cnd);
        end
    endtask

    task automatic test_exception_gate();
        // flags are zf=0 sf=1 of=1 from the previous test
        idle();
        opq(64'h0, 1'b0);
        m_stat = S_ADR;
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b0110) begin
            n_bad++;
            $display("FAIL exc_m_adr: got zf/sf/of/upd=%b required 0110", {zf, sf, of, cc_upd});
        end
        m_stat = S_AOK;
        w_stat = S_HLT;
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b0110) begin
            n_bad++;
            $display("FAIL exc_w_hlt: got zf/sf/of/upd=%b required 0110", {zf, sf, of, cc_upd});
        end
        w_stat = S_AOK;
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b1001) begin
            n_bad++;
            $display("FAIL exc_recover: got zf/sf/of/upd=%b required 1001", {zf, sf, of, cc_upd});
        end
    endtask

    task automatic test_reset_priority();
        idle();
        opq(64'h8000_0000_0000_0000, 1'b1);
        tick();
        opq(64'h5, 1'b0);
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL rst_wins: got zf/sf/of/upd=%b required 1000", {zf, sf, of, cc_upd});
        end
        reset   = 1'b0;
        e_icode = I_OPQ;
        e_ifun  = C_YES;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL opq_not_cond: got e_cnd=%b required 0", e_cnd);
        end
        // same-cycle alu_result must not leak into e_cnd
        e_icode    = I_JXX;
        e_ifun     = C_E;
        alu_result = 64'h1234;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL je_held_flags: got e_cnd=%b required 1", e_cnd);
        end
        e_icode = I_HALT;
        #1;
        n_cmp++;
        if (e_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_not_cond: got e_cnd=%b required 0", e_cnd);
        end
        tick();
        n_cmp++;
        if ({zf, sf, of, cc_upd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL halt_no_update: got zf/sf/of/upd=%b required 1000", {zf, sf, of, cc_upd});
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_zero_result();
        test_negative();
        test_overflow();
        test_exception_gate();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
